// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Holds the controller state encoding and the helper functions that
// derive line geometry (beats per line, tag width, beat counter width)
// from the top-level parameters.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    RESP,
    FLUSH
  } state_t;

  // Number of refill beats needed to fill one line.
  function automatic int beatCount(input int lineBytes, input int busWidth);
    return (lineBytes * 8) / busWidth;
  endfunction

  // Tag width left over once index and line offset are removed.
  function automatic int tagWidth(input int addrWidth, input int setNumber, input int lineBytes);
    return addrWidth - $clog2(setNumber) - $clog2(lineBytes);
  endfunction

  // Beat counter width; kept at least one bit for single-beat lines.
  function automatic int cntWidth(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/cache_ram.sv
// One data way of the instruction cache.
// Ports:
//   clk      - clock
//   i_we     - write one refill beat
//   i_waddr  - beat row ({set, beat})
//   i_wdata  - beat data, BUS_WIDTH bits
//   i_raddr  - 32-bit word address ({set, word select})
//   o_rdata  - selected instruction word (combinational read)
module cache_ram #(
  parameter int DEPTH     = 512,
  parameter int BUS_WIDTH = 64
) (
  input  logic                                  clk,
  input  logic                                  i_we,
  input  logic [$clog2(DEPTH)-1:0]              i_waddr,
  input  logic [BUS_WIDTH-1:0]                  i_wdata,
  input  logic [$clog2(DEPTH*BUS_WIDTH/32)-1:0] i_raddr,
  output logic [31:0]                           o_rdata
);

  localparam int WPB = BUS_WIDTH / 32;
  localparam int RW  = $clog2(DEPTH * WPB);

  // Stored as 32-bit words so the read side needs no beat-to-word mux;
  // a beat lands little-endian across WPB consecutive words.
  logic [31:0] r_mem [DEPTH*WPB];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < WPB; k++) begin
        r_mem[RW'(int'(i_waddr) * WPB + k)] <= i_wdata[32*k +: 32];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU state for the instruction cache.
// Ports:
//   clk, rst  - clock, synchronous active-low reset
//   i_clear   - clear every set's tree (flush)
//   i_idx     - set being looked up / updated
//   i_update  - record an access to way i_way in set i_idx
//   i_way     - accessed way
//   o_victim  - way the tree points at for set i_idx
// Tree nodes are heap-ordered: node n has children 2n+1 (left) and 2n+2
// (right); a node bit of 1 means "the older side is to the right".
module icache_plru #(
  parameter int WAY_NUMBER = 4,
  parameter int SET_NUMBER = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic [$clog2(SET_NUMBER)-1:0] i_idx,
  input  logic                          i_update,
  input  logic [$clog2(WAY_NUMBER)-1:0] i_way,
  output logic [$clog2(WAY_NUMBER)-1:0] o_victim
);

  localparam int WAY_W = $clog2(WAY_NUMBER);

  logic [WAY_NUMBER-2:0] r_bits [SET_NUMBER];
  logic [WAY_NUMBER-1:0] w_cur;
  logic [WAY_NUMBER-1:0] w_next;
  logic                  w_unused;

  // Padded by one bit so any node index fits in WAY_W bits.
  assign w_cur    = {1'b0, r_bits[i_idx]};
  assign w_unused = w_next[WAY_NUMBER-1];

  // Follow the node bits from the root down to a leaf.
  always_comb begin
    int node;
    node     = 0;
    o_victim = '0;
    for (int l = 0; l < WAY_W; l++) begin
      o_victim[WAY_W-1-l] = w_cur[WAY_W'(node)];
      node = 2 * node + 1 + int'(w_cur[WAY_W'(node)]);
    end
  end

  // Walk the accessed way's path and point each node the other way.
  always_comb begin
    int   node;
    logic dir;
    node   = 0;
    w_next = w_cur;
    for (int l = 0; l < WAY_W; l++) begin
      dir = i_way[WAY_W-1-l];
      w_next[WAY_W'(node)] = ~dir;
      node = 2 * node + 1 + int'(dir);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      for (int s = 0; s < SET_NUMBER; s++) begin
        r_bits[s] <= '0;
      end
    end else if (i_update) begin
      r_bits[i_idx] <= w_next[WAY_NUMBER-2:0];
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache between fetch and the AXI read master.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   req_valid_i/ready_o - fetch request handshake, req_addr_i word address
//   resp_valid_o/data_o - one-cycle response pulse with the instruction word
//   flush_i             - invalidate all lines (fence.i)
//   err_o               - one-cycle pulse on a malformed refill burst
//   axi_r_req/addr/gnt  - line read request, held until granted
//   axi_r_valid_i/data_i/last_i - refill beats
module icache_assoc
  import icache_pkg::*;
#(
  parameter int WAY_NUMBER = 4,
  parameter int SET_NUMBER = 64,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int BUS_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_data_o,
  input  logic                  flush_i,
  output logic                  err_o,
  output logic                  axi_r_req,
  output logic [ADDR_WIDTH-1:0] axi_r_addr,
  input  logic                  axi_r_gnt,
  input  logic                  axi_r_valid_i,
  input  logic [BUS_WIDTH-1:0]  axi_r_data_i,
  input  logic                  axi_r_last_i
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(SET_NUMBER);
  localparam int TAG_W = tagWidth(ADDR_WIDTH, SET_NUMBER, LINE_BYTES);
  localparam int BEATS = beatCount(LINE_BYTES, BUS_WIDTH);
  localparam int CNT_W = cntWidth(BEATS);
  localparam int WAY_W = $clog2(WAY_NUMBER);
  localparam int DEPTH = SET_NUMBER * BEATS;
  localparam int ROW_W = $clog2(DEPTH);

  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_addr, r_axiAddr;
  logic [WAY_W-1:0]        r_victim, w_victim, w_hitWay, w_plruVictim, w_plruWay;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_flushPend, r_respValid, r_err;
  logic [31:0]             r_respData;
  logic [SET_NUMBER-1:0]   r_valid [WAY_NUMBER];
  logic [TAG_W-1:0]        r_tag   [WAY_NUMBER][SET_NUMBER];
  logic [31:0]             w_rdata [WAY_NUMBER];
  logic [IDX_W-1:0]        w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic [IDX_W+OFF_W-3:0]  w_word;
  logic [ROW_W-1:0]        w_waddr;
  logic w_hit, w_accept, w_flushNow, w_plruUpd, w_clear, w_isFinal;
  logic w_we, w_refillDone, w_refillErr, w_unused;

  assign w_idx    = r_addr[OFF_W+IDX_W-1:OFF_W];
  assign w_tag    = r_addr[ADDR_WIDTH-1:OFF_W+IDX_W];
  assign w_word   = r_addr[OFF_W+IDX_W-1:2];
  assign w_unused = ^r_addr[1:0];

  assign w_accept     = req_valid_i && req_ready_o;
  assign w_flushNow   = flush_i || r_flushPend;
  assign w_clear      = (r_state == FLUSH);
  assign w_isFinal    = (r_cnt == CNT_W'(BEATS - 1));
  assign w_we         = rst && (r_state == REFILL) && axi_r_valid_i;
  // A burst is well formed only if last coincides exactly with the final beat.
  assign w_refillDone = w_we && w_isFinal && axi_r_last_i;
  assign w_refillErr  = w_we && (w_isFinal != axi_r_last_i);
  assign w_waddr      = ROW_W'(int'(w_idx) * BEATS + int'(r_cnt));

  assign resp_valid_o = r_respValid;
  assign resp_data_o  = r_respData;
  assign err_o        = r_err;
  assign axi_r_req    = (r_state == MISS_REQ);
  assign axi_r_addr   = r_axiAddr;

  // Tag compare across ways, and victim choice: lowest invalid way first,
  // otherwise whatever the PLRU tree points at.
  always_comb begin
    logic found;
    w_hit    = 1'b0;
    w_hitWay = '0;
    w_victim = w_plruVictim;
    found    = 1'b0;
    for (int w = 0; w < WAY_NUMBER; w++) begin
      if (!w_hit && r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit    = 1'b1;
        w_hitWay = WAY_W'(w);
      end
      if (!found && !r_valid[w][w_idx]) begin
        found    = 1'b1;
        w_victim = WAY_W'(w);
      end
    end
  end

  // Next state and handshake. LOOKUP only accepts a follow-on request when
  // it hits, so a missing lookup never has a second request to lose.
  always_comb begin
    w_next      = r_state;
    req_ready_o = 1'b0;
    w_plruUpd   = 1'b0;
    w_plruWay   = w_hitWay;
    case (r_state)
      IDLE: begin
        req_ready_o = !w_flushNow;
        if (w_flushNow)       w_next = FLUSH;
        else if (req_valid_i) w_next = LOOKUP;
      end
      LOOKUP: begin
        if (w_hit) begin
          req_ready_o = !w_flushNow;
          w_plruUpd   = 1'b1;
          if (w_flushNow)       w_next = FLUSH;
          else if (req_valid_i) w_next = LOOKUP;
          else                  w_next = IDLE;
        end else begin
          w_next = MISS_REQ;
        end
      end
      MISS_REQ: if (axi_r_gnt) w_next = REFILL;
      REFILL: begin
        if (w_refillDone) begin
          w_next    = RESP;
          w_plruUpd = 1'b1;
          w_plruWay = r_victim;
        end else if (w_refillErr) begin
          w_next = IDLE;
        end
      end
      RESP:    w_next = w_flushNow ? FLUSH : IDLE;
      FLUSH:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (!rst) req_ready_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_axiAddr   <= '0;
      r_victim    <= '0;
      r_cnt       <= '0;
      r_flushPend <= 1'b0;
      r_respValid <= 1'b0;
      r_respData  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_respValid <= 1'b0;
      r_err       <= 1'b0;
      if (w_accept) r_addr <= req_addr_i;
      case (r_state)
        LOOKUP: begin
          if (w_hit) begin
            r_respValid <= 1'b1;
            r_respData  <= w_rdata[w_hitWay];
          end else begin
            r_victim  <= w_victim;
            r_axiAddr <= {w_tag, w_idx, {OFF_W{1'b0}}};
            r_cnt     <= '0;
          end
        end
        REFILL: begin
          if (axi_r_valid_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_refillErr) r_err <= 1'b1;
          end
        end
        RESP: begin
          r_respValid <= 1'b1;
          r_respData  <= w_rdata[r_victim];
        end
        default: ;
      endcase
      // A flush that arrives while a miss is in flight waits for it to finish.
      if (r_state == FLUSH)
        r_flushPend <= 1'b0;
      else if (flush_i && (r_state != IDLE) && !((r_state == LOOKUP) && w_hit))
        r_flushPend <= 1'b1;
    end
  end

  // The victim is invalidated as soon as it is chosen, so an aborted or
  // malformed refill leaves it invalid without extra bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst || w_clear) begin
      for (int w = 0; w < WAY_NUMBER; w++) begin
        r_valid[w] <= '0;
      end
    end else if ((r_state == LOOKUP) && !w_hit) begin
      r_valid[w_victim][w_idx] <= 1'b0;
    end else if (w_refillDone) begin
      r_valid[r_victim][w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_refillDone) r_tag[r_victim][w_idx] <= w_tag;
  end

  icache_plru #(
    .WAY_NUMBER(WAY_NUMBER),
    .SET_NUMBER(SET_NUMBER)
  ) uPlru (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_idx    (w_idx),
    .i_update (w_plruUpd),
    .i_way    (w_plruWay),
    .o_victim (w_plruVictim)
  );

  for (genvar g = 0; g < WAY_NUMBER; g++) begin : gWay
    cache_ram #(
      .DEPTH     (DEPTH),
      .BUS_WIDTH (BUS_WIDTH)
    ) uRam (
      .clk     (clk),
      .i_we    (w_we && (r_victim == WAY_W'(g))),
      .i_waddr (w_waddr),
      .i_wdata (axi_r_data_i),
      .i_raddr (w_word),
      .o_rdata (w_rdata[g])
    );
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc at default geometry (4 ways, 64 sets,
// 64-byte lines, 64-bit beats). Inputs change and outputs are sampled on
// the falling edge. Line data is a function of the line address, so every
// expected word is derived from the address alone.
module tb_icache_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        flush_i;
  logic        err_o;
  logic        axi_r_req;
  logic [63:0] axi_r_addr;
  logic        axi_r_gnt;
  logic        axi_r_valid_i;
  logic [63:0] axi_r_data_i;
  logic        axi_r_last_i;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  icache_assoc dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .resp_valid_o  (resp_valid_o),
    .resp_data_o   (resp_data_o),
    .flush_i       (flush_i),
    .err_o         (err_o),
    .axi_r_req     (axi_r_req),
    .axi_r_addr    (axi_r_addr),
    .axi_r_gnt     (axi_r_gnt),
    .axi_r_valid_i (axi_r_valid_i),
    .axi_r_data_i  (axi_r_data_i),
    .axi_r_last_i  (axi_r_last_i)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Word w of the line at lineAddr: even words 0xA0+w/2, odd 0xB0+w/2,
  // offset by the line number so different lines hold different data.
  function automatic logic [31:0] expWord(input logic [63:0] lineAddr, input int w);
    logic [31:0] base;
    base = 32'({lineAddr[23:6], 12'h000});
    return base + (((w % 2) == 1) ? 32'hB0 : 32'hA0) + 32'(w / 2);
  endfunction

  // Present one request for one cycle; it must be accepted.
  task automatic applyStimulus(input logic [63:0] addr);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    #1;
    checkOutput("ready before accept", 64'(req_ready_o), 64'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic fetchHit(input logic [63:0] addr);
    applyStimulus(addr);
    @(negedge clk);
    checkOutput("hit valid", 64'(resp_valid_o), 64'd1);
    checkOutput("hit data", 64'(resp_data_o), 64'(expWord(addr & ~64'h3F, int'(addr[5:2]))));
    checkOutput("hit no axi req", 64'(axi_r_req), 64'd0);
  endtask

  // Full miss: optional grant stall, flush on a beat, early last on a
  // beat (protocol error) or reset on a beat. Negative means unused.
  task automatic fetchMiss(input logic [63:0] addr, input int gntDelay, input int flushBeat,
                           input int errBeat, input int rstBeat);
    logic [63:0] la;
    la = addr & ~64'h3F;
    applyStimulus(addr);
    checkOutput("lookup no resp", 64'(resp_valid_o), 64'd0);
    @(negedge clk);
    checkOutput("miss req", 64'(axi_r_req), 64'd1);
    checkOutput("miss addr", axi_r_addr, la);
    for (int i = 0; i < gntDelay; i++) begin
      @(negedge clk);
      checkOutput("stall req", 64'(axi_r_req), 64'd1);
      checkOutput("stall addr", axi_r_addr, la);
    end
    axi_r_gnt = 1'b1;
    @(negedge clk);
    axi_r_gnt = 1'b0;
    checkOutput("req drop after gnt", 64'(axi_r_req), 64'd0);
    for (int b = 0; b < 8; b++) begin
      axi_r_valid_i = 1'b1;
      axi_r_data_i  = {expWord(la, 2 * b + 1), expWord(la, 2 * b)};
      axi_r_last_i  = (b == 7) || (b == errBeat);
      flush_i       = (b == flushBeat);
      if (b == rstBeat) rst = 1'b0;
      @(negedge clk);
      flush_i = 1'b0;
      if (b == rstBeat) begin
        checkOutput("rst ready", 64'(req_ready_o), 64'd0);
        checkOutput("rst resp valid", 64'(resp_valid_o), 64'd0);
        checkOutput("rst resp data", 64'(resp_data_o), 64'd0);
        checkOutput("rst err", 64'(err_o), 64'd0);
        checkOutput("rst axi req", 64'(axi_r_req), 64'd0);
        checkOutput("rst axi addr", axi_r_addr, 64'd0);
        rst = 1'b1;
      end
      if (b == errBeat) begin
        checkOutput("err pulse", 64'(err_o), 64'd1);
        checkOutput("no resp on err", 64'(resp_valid_o), 64'd0);
      end
      if ((errBeat >= 0) && (b == errBeat + 1))
        checkOutput("err single pulse", 64'(err_o), 64'd0);
    end
    axi_r_valid_i = 1'b0;
    axi_r_last_i  = 1'b0;
    if ((errBeat < 0) && (rstBeat < 0)) begin
      checkOutput("resp not early", 64'(resp_valid_o), 64'd0);
      @(negedge clk);
      checkOutput("miss resp valid", 64'(resp_valid_o), 64'd1);
      checkOutput("miss resp data", 64'(resp_data_o), 64'(expWord(la, int'(addr[5:2]))));
      if (flushBeat >= 0)
        checkOutput("flush blocks ready", 64'(req_ready_o), 64'd0);
      @(negedge clk);
      checkOutput("resp single pulse", 64'(resp_valid_o), 64'd0);
    end else begin
      @(negedge clk);
      checkOutput("no resp after abort", 64'(resp_valid_o), 64'd0);
      checkOutput("no err after abort", 64'(err_o), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; flush_i = 1'b0;
    axi_r_gnt = 1'b0; axi_r_valid_i = 1'b0; axi_r_data_i = '0; axi_r_last_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset ready", 64'(req_ready_o), 64'd0);
    checkOutput("reset resp valid", 64'(resp_valid_o), 64'd0);
    checkOutput("reset resp data", 64'(resp_data_o), 64'd0);
    checkOutput("reset err", 64'(err_o), 64'd0);
    checkOutput("reset axi req", 64'(axi_r_req), 64'd0);
    checkOutput("reset axi addr", axi_r_addr, 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("ready after reset", 64'(req_ready_o), 64'd1);
    @(negedge clk);

    $display("[TB] cold miss and hit");
    fetchMiss(64'h8000_0000, 0, -1, -1, -1);
    fetchHit(64'h8000_000C);

    $display("[TB] back-to-back hits");
    req_valid_i = 1'b1;
    req_addr_i  = 64'h8000_0000;
    @(negedge clk);
    req_addr_i  = 64'h8000_0004;
    checkOutput("b2b ready in lookup", 64'(req_ready_o), 64'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    checkOutput("b2b first valid", 64'(resp_valid_o), 64'd1);
    checkOutput("b2b first data", 64'(resp_data_o), 64'h0000_00A0);
    @(negedge clk);
    checkOutput("b2b second valid", 64'(resp_valid_o), 64'd1);
    checkOutput("b2b second data", 64'(resp_data_o), 64'h0000_00B0);

    $display("[TB] plru eviction with grant stall");
    fetchMiss(64'h8000_1000, 0, -1, -1, -1);
    fetchMiss(64'h8000_2000, 0, -1, -1, -1);
    fetchMiss(64'h8000_3000, 0, -1, -1, -1);
    fetchHit(64'h8000_0000);
    fetchMiss(64'h8000_4000, 5, -1, -1, -1);
    fetchMiss(64'h8000_2000, 0, -1, -1, -1);
    fetchHit(64'h8000_0000);
    fetchHit(64'h8000_3000);
    fetchHit(64'h8000_4004);

    $display("[TB] flush during refill");
    fetchMiss(64'h8000_5000, 0, 3, -1, -1);
    fetchMiss(64'h8000_5000, 0, -1, -1, -1);

    $display("[TB] flush wins over request in idle");
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i  = 64'h8000_5000;
    #1;
    checkOutput("flush idle ready", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    checkOutput("flush cycle ready", 64'(req_ready_o), 64'd0);
    checkOutput("flush no resp", 64'(resp_valid_o), 64'd0);
    @(negedge clk);
    checkOutput("ready after flush", 64'(req_ready_o), 64'd1);
    fetchMiss(64'h8000_5004, 0, -1, -1, -1);

    $display("[TB] reset mid-refill");
    fetchMiss(64'h8000_6000, 0, -1, -1, 4);
    fetchMiss(64'h8000_6000, 0, -1, -1, -1);

    $display("[TB] early last");
    fetchMiss(64'h8000_7000, 0, -1, 5, -1);
    fetchMiss(64'h8000_7008, 0, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
